// File: rtl/tiny_riscv_load_store.sv
// Load/store unit between the execute stage and a word-wide data memory.
// Converts byte/halfword/word requests into word accesses with byte masks and
// extracts/extends load data. Optional macro LSU_MISALIGN_TRAP_EN turns
// misaligned halfword/word accesses into errors; when undefined they are
// silently aligned down.
module tiny_riscv_load_store #(
    parameter int unsigned MEM_BYTES = 6144
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_req_funct3,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_error,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_read_strobe,
    output logic [31:0] o_mem_write_data,
    output logic [3:0]  o_mem_write_mask,
    input  logic [31:0] i_mem_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [2:0]  funct3_q, funct3_n;
    logic        write_q, write_n;
    logic [1:0]  off_q, off_n;

    logic        ready_n, strobe_n, valid_n, error_n;
    logic [3:0]  mask_n;
    logic [31:0] wdata_n, addr_n, rdata_n;

    logic        illegal, out_of_range, misaligned, req_error;
    logic [31:0] eff_addr, shifted, load_value;

    // Request decode: error classification and effective (aligned) address
    always_comb begin
        if (i_req_write)
            illegal = (i_req_funct3 >= 3'b011);
        else
            illegal = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                      (i_req_funct3 == 3'b111);
        out_of_range = (i_req_addr >= MEM_BYTES);
        eff_addr     = i_req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                     ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
        if (i_req_funct3[1:0] == 2'b01) eff_addr[0]   = 1'b0;
        if (i_req_funct3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
`endif
        req_error = illegal || out_of_range || misaligned;
    end

    // Load data extraction: shift addressed bytes down, then sign/zero extend
    always_comb begin
        shifted = i_mem_data >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_value = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_value = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_value = shifted;
            3'b100:  load_value = {24'd0, shifted[7:0]};
            3'b101:  load_value = {16'd0, shifted[15:0]};
            default: load_value = '0;
        endcase
    end

    // Next-state and next-output logic; every output is registered from these
    always_comb begin
        state_next = state;
        funct3_n   = funct3_q;
        write_n    = write_q;
        off_n      = off_q;
        ready_n    = 1'b0;
        strobe_n   = 1'b0;
        valid_n    = 1'b0;
        error_n    = 1'b0;
        mask_n     = '0;
        wdata_n    = '0;
        addr_n     = o_mem_addr;
        rdata_n    = '0;
        case (state)
            IDLE: begin
                if (i_req_valid && o_req_ready) begin
                    funct3_n = i_req_funct3;
                    write_n  = i_req_write;
                    off_n    = eff_addr[1:0];
                    if (req_error) begin
                        state_next = RESP;
                        valid_n    = 1'b1;
                        error_n    = 1'b1;
                    end else begin
                        state_next = ISSUE;
                        addr_n     = {eff_addr[31:2], 2'b00};
                        if (i_req_write) begin
                            case (i_req_funct3[1:0])
                                2'b00: begin
                                    wdata_n = {4{i_req_wdata[7:0]}};
                                    mask_n  = 4'b0001 << eff_addr[1:0];
                                end
                                2'b01: begin
                                    wdata_n = {2{i_req_wdata[15:0]}};
                                    mask_n  = 4'b0011 << {eff_addr[1], 1'b0};
                                end
                                default: begin
                                    wdata_n = i_req_wdata;
                                    mask_n  = 4'b1111;
                                end
                            endcase
                        end else begin
                            strobe_n = 1'b1;
                        end
                    end
                end else begin
                    ready_n = 1'b1;
                end
            end
            ISSUE: begin
                if (write_q) begin
                    state_next = RESP;
                    valid_n    = 1'b1;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = RESP;
                valid_n    = 1'b1;
                rdata_n    = load_value;
            end
            default: begin
                state_next = IDLE;
                ready_n    = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state             <= IDLE;
            funct3_q          <= '0;
            write_q           <= 1'b0;
            off_q             <= '0;
            o_req_ready       <= 1'b0;
            o_rsp_valid       <= 1'b0;
            o_rsp_rdata       <= '0;
            o_rsp_error       <= 1'b0;
            o_mem_addr        <= '0;
            o_mem_read_strobe <= 1'b0;
            o_mem_write_data  <= '0;
            o_mem_write_mask  <= '0;
        end else begin
            state             <= state_next;
            funct3_q          <= funct3_n;
            write_q           <= write_n;
            off_q             <= off_n;
            o_req_ready       <= ready_n;
            o_rsp_valid       <= valid_n;
            o_rsp_rdata       <= rdata_n;
            o_rsp_error       <= error_n;
            o_mem_addr        <= addr_n;
            o_mem_read_strobe <= strobe_n;
            o_mem_write_data  <= wdata_n;
            o_mem_write_mask  <= mask_n;
        end
    end

endmodule

// File: tb/tb_tiny_riscv_load_store.sv
// Directed bench for tiny_riscv_load_store with a behavioural word memory.
module tb_tiny_riscv_load_store;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_addr;
    logic        mem_read_strobe;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_mask;
    logic [31:0] mem_data = '0;

    int checks = 0;
    int passes = 0;

    bit [31:0] mem [0:2047];

    tiny_riscv_load_store #(.MEM_BYTES(6144)) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_write(req_write),
        .i_req_addr(req_addr),
        .i_req_wdata(req_wdata),
        .i_req_funct3(req_funct3),
        .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_error(rsp_error),
        .o_mem_addr(mem_addr),
        .o_mem_read_strobe(mem_read_strobe),
        .o_mem_write_data(mem_write_data),
        .o_mem_write_mask(mem_write_mask),
        .i_mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory: byte-masked writes, read data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_read_strobe) mem_data <= mem[mem_addr[12:2]];
        for (int k = 0; k < 4; k++)
            if (mem_write_mask[k]) mem[mem_addr[12:2]][8*k +: 8] <= mem_write_data[8*k +: 8];
    end

    // Issue one request and observe it until the response; lat is the index of
    // the edge after which o_rsp_valid appeared (accept edge = 0), -1 on timeout
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output logic [31:0] rdata,
                          output logic err, output int strobes, output int masks,
                          output logic [3:0] mseen, output logic [31:0] dseen,
                          output logic [31:0] aseen);
        int waited = 0;
        lat = -1; rdata = '0; err = 1'b0; strobes = 0; masks = 0;
        mseen = '0; dseen = '0; aseen = '0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready) begin
            req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (mem_read_strobe) begin strobes++; aseen = mem_addr; end
                if (mem_write_mask != 4'b0000) begin
                    masks++; mseen = mem_write_mask; dseen = mem_write_data; aseen = mem_addr;
                end
                if (rsp_valid) begin
                    lat = k; rdata = rsp_rdata; err = rsp_error;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_read_strobe,
             mem_write_data, mem_write_mask} !== '0)
            $display("FAIL reset_outputs got ready=%b valid=%b mask=%h strobe=%b want all 0",
                     req_ready, rsp_valid, mem_write_mask, mem_read_strobe);
        else passes++;
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_low got %b want 0", req_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready_rise got %b want 1", req_ready);
        else passes++;
    endtask

    task automatic test_word();
        int lat, st, mk; logic [31:0] rd, ds, as; logic er; logic [3:0] ms;
        do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h0)
            $display("FAIL sw_rsp got lat=%0d err=%b rdata=%h want lat=1 err=0 rdata=0", lat, er, rd);
        else passes++;
        checks++;
        if (mk !== 1 || ms !== 4'b1111 || ds !== 32'hDEADBEEF || as !== 32'h100 || st !== 0)
            $display("FAIL sw_mem got masks=%0d mask=%h data=%h addr=%h strobes=%0d want 1 f deadbeef 100 0",
                     mk, ms, ds, as, st);
        else passes++;
        do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF)
            $display("FAIL lw_rsp got lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=deadbeef", lat, er, rd);
        else passes++;
        checks++;
        if (st !== 1 || mk !== 0 || as !== 32'h100)
            $display("FAIL lw_mem got strobes=%0d masks=%0d addr=%h want 1 0 100", st, mk, as);
        else passes++;
    endtask

    task automatic test_byte();
        int lat, st, mk; logic [31:0] rd, ds, as; logic er; logic [3:0] ms;
        do_req(1'b1, 3'b000, 32'h103, 32'h000000A5, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 1 || er !== 1'b0 || mk !== 1 || ms !== 4'b1000 || ds !== 32'hA5A5A5A5 || as !== 32'h100)
            $display("FAIL sb got lat=%0d err=%b masks=%0d mask=%h data=%h addr=%h want 1 0 1 8 a5a5a5a5 100",
                     lat, er, mk, ms, ds, as);
        else passes++;
        do_req(1'b0, 3'b000, 32'h103, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hFFFFFFA5)
            $display("FAIL lb got lat=%0d err=%b rdata=%h want 2 0 ffffffa5", lat, er, rd);
        else passes++;
        do_req(1'b0, 3'b100, 32'h103, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h000000A5)
            $display("FAIL lbu got lat=%0d err=%b rdata=%h want 2 0 000000a5", lat, er, rd);
        else passes++;
        do_req(1'b0, 3'b100, 32'h101, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (rd !== 32'h000000BE) $display("FAIL lbu_lane1 got rdata=%h want 000000be", rd);
        else passes++;
    endtask

    task automatic test_half();
        int lat, st, mk; logic [31:0] rd, ds, as; logic er; logic [3:0] ms;
        do_req(1'b1, 3'b001, 32'h102, 32'h00008001, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 1 || er !== 1'b0 || mk !== 1 || ms !== 4'b1100 || ds !== 32'h80018001)
            $display("FAIL sh got lat=%0d err=%b masks=%0d mask=%h data=%h want 1 0 1 c 80018001",
                     lat, er, mk, ms, ds);
        else passes++;
        do_req(1'b0, 3'b001, 32'h102, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hFFFF8001)
            $display("FAIL lh got lat=%0d err=%b rdata=%h want 2 0 ffff8001", lat, er, rd);
        else passes++;
        do_req(1'b0, 3'b101, 32'h102, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h00008001)
            $display("FAIL lhu got lat=%0d err=%b rdata=%h want 2 0 00008001", lat, er, rd);
        else passes++;
        do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (rd !== 32'h8001BEEF) $display("FAIL lw_merged got rdata=%h want 8001beef", rd);
        else passes++;
    endtask

    task automatic test_errors();
        int lat, st, mk; logic [31:0] rd, ds, as; logic er; logic [3:0] ms;
        logic        v_w  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  v_f3 [5] = '{3'b010, 3'b011, 3'b111, 3'b011, 3'b000};
        logic [31:0] v_a  [5] = '{32'd6144, 32'h100, 32'h100, 32'h100, 32'd6144};
        for (int i = 0; i < 5; i++) begin
            do_req(v_w[i], v_f3[i], v_a[i], 32'h55AA55AA, lat, rd, er, st, mk, ms, ds, as);
            checks++;
            if (lat !== 0 || er !== 1'b1 || rd !== 32'h0 || st !== 0 || mk !== 0)
                $display("FAIL err_case%0d got lat=%0d err=%b rdata=%h strobes=%0d masks=%0d want 0 1 0 0 0",
                         i, lat, er, rd, st, mk);
            else passes++;
        end
        do_req(1'b0, 3'b000, 32'd6143, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || st !== 1)
            $display("FAIL lb_last_byte got lat=%0d err=%b rdata=%h strobes=%0d want 2 0 0 1",
                     lat, er, rd, st);
        else passes++;
    endtask

    task automatic test_misalign();
        int lat, st, mk; logic [31:0] rd, ds, as; logic er; logic [3:0] ms;
        do_req(1'b0, 3'b010, 32'h101, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (lat !== 0 || er !== 1'b1 || st !== 0 || rd !== 32'h0)
            $display("FAIL lw_misaligned got lat=%0d err=%b strobes=%0d rdata=%h want 0 1 0 0", lat, er, st, rd);
`else
        if (lat !== 2 || er !== 1'b0 || as !== 32'h100 || rd !== 32'h8001BEEF)
            $display("FAIL lw_misaligned got lat=%0d err=%b addr=%h rdata=%h want 2 0 100 8001beef",
                     lat, er, as, rd);
`endif
        else passes++;
        do_req(1'b0, 3'b001, 32'h103, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (lat !== 0 || er !== 1'b1 || st !== 0)
            $display("FAIL lh_misaligned got lat=%0d err=%b strobes=%0d want 0 1 0", lat, er, st);
`else
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hFFFF8001)
            $display("FAIL lh_misaligned got lat=%0d err=%b rdata=%h want 2 0 ffff8001", lat, er, rd);
`endif
        else passes++;
    endtask

    task automatic test_back_to_back();
        int first, gap, n;
        logic        v_w  [2] = '{1'b0, 1'b1};
        logic [2:0]  v_f3 [2] = '{3'b010, 3'b010};
        logic [31:0] v_a  [2] = '{32'h100, 32'h104};
        int          v_g  [2] = '{4, 3};
        for (int i = 0; i < 2; i++) begin
            first = -1; gap = -1; n = 0;
            req_valid = 1'b1; req_write = v_w[i]; req_funct3 = v_f3[i];
            req_addr = v_a[i]; req_wdata = 32'h12345678;
            while (gap < 0 && n < 30) begin
                @(negedge clk);
                n++;
                if (rsp_valid) begin
                    if (first < 0) first = n;
                    else gap = n - first;
                end
            end
            req_valid = 1'b0;
            repeat (6) @(negedge clk);
            checks++;
            if (gap !== v_g[i]) $display("FAIL b2b_gap%0d got %0d want %0d", i, gap, v_g[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_midop();
        int lat, st, mk, rsp_seen; logic [31:0] rd, ds, as; logic er; logic [3:0] ms;
        rsp_seen = 0;
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mem_read_strobe !== 1'b1) $display("FAIL midop_strobe got %b want 1", mem_read_strobe);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_error, mem_addr, mem_read_strobe,
             mem_write_data, mem_write_mask} !== '0)
            $display("FAIL midop_clear got ready=%b valid=%b addr=%h strobe=%b want all 0",
                     req_ready, rsp_valid, mem_addr, mem_read_strobe);
        else passes++;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        rst = 1'b0;
        #1;
        if (rsp_valid) rsp_seen++;
        checks++;
        if (req_ready !== 1'b0) $display("FAIL midop_ready_low got %b want 0", req_ready);
        else passes++;
        @(negedge clk);
        if (rsp_valid) rsp_seen++;
        checks++;
        if (req_ready !== 1'b1 || rsp_seen !== 0)
            $display("FAIL midop_release got ready=%b rsp_pulses=%0d want 1 0", req_ready, rsp_seen);
        else passes++;
        do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, er, st, mk, ms, ds, as);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'h8001BEEF)
            $display("FAIL midop_next_lw got lat=%0d err=%b rdata=%h want 2 0 8001beef", lat, er, rd);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_misalign();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tiny_riscv_load_store.md
# tiny_riscv_load_store

Load/store unit between the CPU execute stage and the word-wide data memory. It accepts one byte/halfword/word load or store request at a time and converts it into a word address, a one-cycle read strobe or a byte write mask with lane-replicated write data. For loads it extracts and sign- or zero-extends the addressed bytes from the returned memory word and reports illegal or out-of-range accesses back to the CPU.

## Interface
- MEM_BYTES, 6144: size of the data memory in bytes; addresses >= MEM_BYTES are access errors.
- i_Clk  in  1  clock; all state updates on the rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  CPU request present.
- o_req_ready  out  1  LSU idle; a request is accepted on an edge where valid && ready.
- i_req_write  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- i_req_funct3  in  3  RISC-V funct3: loads LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
- o_rsp_valid  out  1  one-cycle completion pulse; the CPU always accepts it.
- o_rsp_rdata  out  32  load result; 0 for stores and errors.
- o_rsp_error  out  1  qualified by o_rsp_valid; illegal funct3, out-of-range or misaligned access.
- o_mem_addr  out  32  {addr[31:2], 2'b00}.
- o_mem_read_strobe  out  1  one-cycle read request.
- o_mem_write_data  out  32  lane-replicated store data.
- o_mem_write_mask  out  4  byte-lane write enables; bit k writes bits [8k+7:8k].
- i_mem_data  in  32  read word, valid the cycle after the strobe cycle; the byte at address offset k is in [8k+7:8k].

## Operation
- States: IDLE, ISSUE, WAIT, RESP. The state and all outputs are registered.
- IDLE: o_req_ready=1. On accept, the LSU latches addr, wdata, funct3 and write, then checks the request:
  - error -> RESP
  - otherwise -> ISSUE
- Errors:
  - Illegal funct3: loads 011, 110, 111; stores >= 011.
  - Out of range: addr >= MEM_BYTES.
  - Misaligned: see Configuration.
- ISSUE, load: o_mem_read_strobe=1 -> WAIT.
- ISSUE, store: o_mem_write_mask is driven, then -> RESP.
  - SB: data = {4{wdata[7:0]}}, mask = 4'b0001 << addr[1:0].
  - SH: data = {2{wdata[15:0]}}, mask = 4'b0011 << {addr[1],1'b0}.
  - SW: data = wdata, mask = 4'b1111.
- WAIT: the LSU captures i_mem_data >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
  - -> RESP.
- RESP: o_rsp_valid=1 with rdata and error -> IDLE.
- o_req_ready=0 in every state other than IDLE. A new request is accepted no earlier than the edge after RESP.
- o_mem_write_mask is 0 and o_mem_read_strobe is 0 outside ISSUE.
- o_mem_addr holds its value from ISSUE through WAIT.
- An errored request performs no memory access: no strobe, no mask.

## Timing
- Accept edge E0. Load: strobe is high after E0, data is captured at E2, o_rsp_valid is high after E2. Throughput is 1 load per 4 cycles.
- Store: mask is high after E0, o_rsp_valid is high after E1. Throughput is 1 store per 3 cycles.
- Error: o_rsp_valid is high after E0.
- Reset values: state IDLE; o_req_ready=0, rising to 1 on the first edge after reset deasserts. Every other output is 0.
- Reset mid-operation: outputs clear immediately and the in-flight access is dropped with no response. A write mask that is cleared before the edge writes nothing.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is an error.
  - The error response comes after E0 and no memory access is made.
- LSU_MISALIGN_TRAP_EN undefined:
  - No misalignment error is raised.
  - Halfword accesses clear addr[0]; word accesses clear addr[1:0].
  - The access proceeds at the aligned address.

## Test plan
- SW addr=0x100 wdata=0xDEADBEEF -> mask 4'b1111 for 1 cycle, o_mem_addr=0x100, rsp after E1 with error=0. Then LW 0x100 -> strobe 1 cycle, rsp after E2 with rdata=0xDEADBEEF.
- SB addr=0x103 wdata=0x000000A5 -> mask 4'b1000, data 0xA5A5A5A5. LB 0x103 -> 0xFFFFFFA5; LBU 0x103 -> 0x000000A5.
- SH addr=0x102 wdata=0x8001 -> mask 4'b1100. LH 0x102 -> 0xFFFF8001; LHU 0x102 -> 0x00008001.
- LW addr=6144, and a load with funct3=011 -> rsp after E0 with error=1, rdata=0, no strobe or mask ever asserted.
- LW addr=0x101:
  - macro defined -> error=1, no strobe.
  - macro undefined -> access to 0x100, error=0.
- Assert i_Reset in WAIT of a load -> o_rsp_valid never pulses and all outputs are 0. o_req_ready rises 1 cycle after release, and the next LW completes normally.
